sdram_arbiter: RTL and testbench

- Schedules four independent SDRAM access requesters onto the single SDRAM controller port, which has an RD/WR/READY handshake.
- Channels: 0 = 68k/CD read, 1 = C-ROM sprite burst, 2 = S-ROM fix read, 3 = CD/DMA write.
- Priority is fixed, with a starvation guard for channel 3.
- Sits between the video/CPU request generators and the SDRAM controller. Returns captured read data and a per-channel completion pulse.

---
 rtl/sdram_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: four-requester scheduler for one SDRAM controller port.
// Fixed priority ch0 > ch1 > ch2 > ch3, with a starvation guard that
// forces ch3 after STARVE_LIMIT lower-channel grants while it waits.
//
// Ports:
//   CLK, RESET        clock, async active-high reset
//   REQ[3:0]          one-cycle request pulses
//   REQ_ADDR          per-channel address, ch n at [n*ADDR_W +: ADDR_W]
//   WR_DATA, WR_BS    ch3 write data / byte selects (taken with REQ[3])
//   SDRAM_RD/WR       command strobes to the controller
//   SDRAM_BURST       64-bit burst read (ch1)
//   SDRAM_ADDR/DIN/BS command address, write data, byte selects
//   SDRAM_DOUT        read data from the controller
//   SDRAM_READY       controller idle / complete
//   RD_DATA           data of the last completed read
//   DONE[3:0]         one-cycle completion pulse per channel
//   OVERRUN[3:0]      sticky: request hit an already-pending channel
//   BUSY              arbiter not in IDLE
//   TIMEOUT           sticky watchdog flag (SDRAM_ARB_TIMEOUT_EN only)
//
// Build option: define SDRAM_ARB_TIMEOUT_EN to add an 8-bit watchdog
// on CMD+WAIT and the TIMEOUT output.
module sdram_arbiter #(
  parameter int ADDR_W       = 26,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [3:0]          REQ,
  input  logic [4*ADDR_W-1:0] REQ_ADDR,
  input  logic [15:0]         WR_DATA,
  input  logic [1:0]          WR_BS,
  output logic                SDRAM_RD,
  output logic                SDRAM_WR,
  output logic                SDRAM_BURST,
  output logic [ADDR_W-1:0]   SDRAM_ADDR,
  output logic [15:0]         SDRAM_DIN,
  output logic [1:0]          SDRAM_BS,
  input  logic [63:0]         SDRAM_DOUT,
  input  logic                SDRAM_READY,
  output logic [63:0]         RD_DATA,
  output logic [3:0]          DONE,
  output logic [3:0]          OVERRUN,
`ifdef SDRAM_ARB_TIMEOUT_EN
  output logic                BUSY,
  output logic                TIMEOUT
`else
  output logic                BUSY
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_FIN
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q;
  logic [3:0]        pend_q;
  logic [3:0]        pend_d;
  logic [ADDR_W-1:0] addr_q [4];
  logic [15:0]       wdata_q;
  logic [1:0]        wbs_q;
  logic [3:0]        starve_q;
  logic [3:0]        starve_d;
  logic [1:0]        grant_q;
  logic              ready_prev_q;

  logic              rd_q;
  logic              wr_q;
  logic              burst_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [15:0]       din_q;
  logic [1:0]        bs_q;
  logic [63:0]       rd_data_q;
  logic [3:0]        done_q;
  logic [3:0]        ovr_q;

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [7:0]        wdog_q;
  logic              timeout_q;
`endif

  logic [ADDR_W-1:0] req_a [4];
  logic [3:0]        acc;
  logic [3:0]        avail;
  logic [3:0]        gmask;
  logic              force3;
  logic              grant_ok;
  logic [1:0]        gsel;
  logic [ADDR_W-1:0] gaddr;
  logic [15:0]       gdata;
  logic [1:0]        gbs;

  // A request arriving this cycle is visible to the grant logic
  // immediately, so an idle arbiter issues the command next cycle.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      req_a[n] = REQ_ADDR[n*ADDR_W +: ADDR_W];
    end
    acc      = REQ & ~pend_q;
    avail    = pend_q | REQ;
    force3   = avail[3] && (starve_q == LIMIT);
    grant_ok = (state_q == S_IDLE) && SDRAM_READY
               && (avail != 4'd0);

    if (force3)        gsel = 2'd3;
    else if (avail[0]) gsel = 2'd0;
    else if (avail[1]) gsel = 2'd1;
    else if (avail[2]) gsel = 2'd2;
    else               gsel = 2'd3;

    gmask  = grant_ok ? (4'd1 << gsel) : 4'd0;
    gaddr  = acc[gsel] ? req_a[gsel] : addr_q[gsel];
    gdata  = acc[3] ? WR_DATA : wdata_q;
    gbs    = acc[3] ? WR_BS : wbs_q;
    pend_d = avail & ~gmask;

    if (grant_ok && gsel == 2'd3)
      starve_d = 4'd0;
    else if (!avail[3])
      starve_d = 4'd0;
    else if (grant_ok && starve_q < LIMIT)
      starve_d = starve_q + 4'd1;
    else
      starve_d = starve_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      for (int n = 0; n < 4; n++) addr_q[n] <= '0;
      wdata_q      <= '0;
      wbs_q        <= '0;
      starve_q     <= '0;
      grant_q      <= '0;
      ready_prev_q <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      burst_q      <= 1'b0;
      cmd_addr_q   <= '0;
      din_q        <= '0;
      bs_q         <= '0;
      rd_data_q    <= '0;
      done_q       <= '0;
      ovr_q        <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      pend_q       <= pend_d;
      starve_q     <= starve_d;
      ready_prev_q <= SDRAM_READY;
      ovr_q        <= ovr_q | (REQ & pend_q);
      done_q       <= '0;
      for (int n = 0; n < 4; n++) begin
        if (acc[n]) addr_q[n] <= req_a[n];
      end
      if (acc[3]) begin
        wdata_q <= WR_DATA;
        wbs_q   <= WR_BS;
      end

      unique case (state_q)
        S_IDLE: begin
          if (grant_ok) begin
            grant_q    <= gsel;
            rd_q       <= (gsel != 2'd3);
            wr_q       <= (gsel == 2'd3);
            burst_q    <= (gsel == 2'd1);
            cmd_addr_q <= gaddr;
            if (gsel == 2'd3) begin
              din_q <= gdata;
              bs_q  <= gbs;
            end else begin
              bs_q  <= 2'b11;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            wdog_q     <= '0;
`endif
            state_q    <= S_CMD;
          end
        end
        S_CMD: begin
          // controller accepted the command once READY falls
          if (ready_prev_q && !SDRAM_READY) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (SDRAM_READY) begin
            if (grant_q != 2'd3) rd_data_q <= SDRAM_DOUT;
            done_q  <= 4'd1 << grant_q;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
      endcase

`ifdef SDRAM_ARB_TIMEOUT_EN
      // watchdog wins over the normal CMD/WAIT progress
      if (state_q == S_CMD || state_q == S_WAIT) begin
        if (wdog_q == 8'hFF) begin
          rd_q      <= 1'b0;
          wr_q      <= 1'b0;
          rd_data_q <= rd_data_q;
          done_q    <= 4'd1 << grant_q;
          timeout_q <= 1'b1;
          state_q   <= S_IDLE;
        end else begin
          wdog_q <= wdog_q + 8'd1;
        end
      end
`endif
    end
  end

  assign SDRAM_RD    = rd_q;
  assign SDRAM_WR    = wr_q;
  assign SDRAM_BURST = burst_q;
  assign SDRAM_ADDR  = cmd_addr_q;
  assign SDRAM_DIN   = din_q;
  assign SDRAM_BS    = bs_q;
  assign RD_DATA     = rd_data_q;
  assign DONE        = done_q;
  assign OVERRUN     = ovr_q;
  assign BUSY        = (state_q != S_IDLE);
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign TIMEOUT     = timeout_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench with an SDRAM responder model
// and a transaction-level reference model of the arbitration rules.
module tb_sdram_arbiter;

  localparam int AW  = 26;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic [15:0]   wr_data = '0;
  logic [1:0]    wr_bs = '0;
  logic [63:0]   dout = '0;
  logic          ready = 1'b1;

  logic          SDRAM_RD, SDRAM_WR, SDRAM_BURST;
  logic [AW-1:0] SDRAM_ADDR;
  logic [15:0]   SDRAM_DIN;
  logic [1:0]    SDRAM_BS;
  logic [63:0]   RD_DATA;
  logic [3:0]    DONE, OVERRUN;
  logic          BUSY;
`ifdef SDRAM_ARB_TIMEOUT_EN
  logic          TIMEOUT;
`endif

  sdram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .CLK(clk), .RESET(rst), .REQ(req), .REQ_ADDR(req_addr),
    .WR_DATA(wr_data), .WR_BS(wr_bs),
    .SDRAM_RD(SDRAM_RD), .SDRAM_WR(SDRAM_WR),
    .SDRAM_BURST(SDRAM_BURST), .SDRAM_ADDR(SDRAM_ADDR),
    .SDRAM_DIN(SDRAM_DIN), .SDRAM_BS(SDRAM_BS),
    .SDRAM_DOUT(dout), .SDRAM_READY(ready),
    .RD_DATA(RD_DATA), .DONE(DONE), .OVERRUN(OVERRUN),
`ifdef SDRAM_ARB_TIMEOUT_EN
    .BUSY(BUSY), .TIMEOUT(TIMEOUT)
`else
    .BUSY(BUSY)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // reference model state
  bit [3:0]      m_pend = '0;
  bit [3:0]      m_ovr = '0;
  logic [AW-1:0] m_addr [4];
  logic [15:0]   m_wd = '0;
  logic [1:0]    m_bs = '0;
  int            m_cnt = 0;
  bit            prev_cmd = 0;
  int            done_exp [$];
  int            gr_log [$];
  logic [63:0]   dq [$];
  logic [63:0]   last_rd = '0;

  // responder controls
  bit            use_fix = 0;
  int            d1_fix = 1;
  int            d2_fix = 1;
  logic [63:0]   data_fix = '0;
  bit            stall = 0;
  bit            tmo_mode = 0;

  function automatic int choose();
    if (m_pend[3] && m_cnt == LIM) return 3;
    for (int i = 0; i < 4; i++) if (m_pend[i]) return i;
    return 3;
  endfunction

  function automatic void clear_model();
    m_pend = '0;
    m_ovr = '0;
    m_cnt = 0;
    prev_cmd = 0;
    done_exp.delete();
    dq.delete();
    gr_log.delete();
    last_rd = '0;
  endfunction

  // Model: a new command must serve the channel the rules pick from
  // everything requested up to the previous cycle.
  always @(negedge clk) begin
    bit cmd;
    int g;
    if (!rst) begin
      cmd = SDRAM_RD | SDRAM_WR;
      if (SDRAM_RD && SDRAM_WR) chk("rd_wr_overlap", 1, 0);
      if (cmd && !prev_cmd) begin
        if (m_pend == 4'd0) begin
          chk("spurious_cmd", 1, 0);
        end else begin
          g = choose();
          chk("cmd_addr", SDRAM_ADDR, m_addr[g]);
          chk("cmd_rd", SDRAM_RD, g != 3);
          chk("cmd_wr", SDRAM_WR, g == 3);
          chk("cmd_burst", SDRAM_BURST, g == 1);
          if (g == 3) begin
            chk("cmd_din", SDRAM_DIN, m_wd);
            chk("cmd_bs_wr", SDRAM_BS, m_bs);
          end else begin
            chk("cmd_bs_rd", SDRAM_BS, 2'b11);
          end
          if (g == 3) m_cnt = 0;
          else if (m_pend[3] && m_cnt < LIM) m_cnt++;
          m_pend[g] = 1'b0;
          done_exp.push_back(g);
          gr_log.push_back(g);
        end
      end
      if (!m_pend[3]) m_cnt = 0;
      prev_cmd = cmd;
      for (int n = 0; n < 4; n++) begin
        if (req[n]) begin
          if (m_pend[n]) begin
            m_ovr[n] = 1'b1;
          end else begin
            m_pend[n] = 1'b1;
            m_addr[n] = req_addr[n*AW +: AW];
            if (n == 3) begin
              m_wd = wr_data;
              m_bs = wr_bs;
            end
          end
        end
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    int ch;
    logic [63:0] d;
    if (!rst && DONE != 4'd0) begin
      if (done_exp.size() == 0) begin
        chk("unexpected_done", DONE, 0);
      end else begin
        ch = done_exp.pop_front();
        chk("done_onehot", DONE, 64'd1 << ch);
        if (tmo_mode) begin
          chk("rd_data_tmo", RD_DATA, last_rd);
        end else if (dq.size() == 0) begin
          chk("done_without_data", 1, 0);
        end else begin
          d = dq.pop_front();
          if (ch != 3) last_rd = d;
          chk("rd_data", RD_DATA, last_rd);
        end
      end
    end
  end

  // SDRAM controller model
  initial begin
    int a, b;
    logic [63:0] data;
    forever begin
      @(negedge clk);
      if (rst || stall || !(SDRAM_RD || SDRAM_WR)) continue;
      a = use_fix ? d1_fix : $urandom_range(1, 3);
      b = use_fix ? d2_fix : $urandom_range(1, 6);
      data = use_fix ? data_fix : {$urandom, $urandom};
      repeat (a) @(posedge clk);
      #1 ready = 1'b0;
      repeat (b) @(posedge clk);
      #1;
      dout = data;
      ready = 1'b1;
      dq.push_back(data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_pend == 4'd0 && done_exp.size() == 0 && !BUSY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timeout busy=%0d pend=%0h", nm,
               BUSY, m_pend);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n0, k, hit;
    bit found;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", SDRAM_RD, 0);
    chk("rst_wr", SDRAM_WR, 0);
    chk("rst_burst", SDRAM_BURST, 0);
    chk("rst_addr", SDRAM_ADDR, 0);
    chk("rst_din", SDRAM_DIN, 0);
    chk("rst_bs", SDRAM_BS, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_done", DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_busy", BUSY, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    // single ch0 read with latency check
    use_fix = 1;
    d1_fix = 2;
    d2_fix = 5;
    data_fix = 64'h1234;
    req = 4'b0001;
    req_addr[0 +: AW] = 26'h0100040;
    @(negedge clk);
    chk("lat_cycle_n_rd", SDRAM_RD, 0);
    tick();
    req = '0;
    @(negedge clk);
    chk("lat_cycle_n1_rd", SDRAM_RD, 1);
    chk("single_addr", SDRAM_ADDR, 26'h0100040);
    chk("single_burst", SDRAM_BURST, 0);
    wait_idle("single_rd");
    chk("single_rd_data", RD_DATA, 64'h1234);
    use_fix = 0;

    // simultaneous ch0..ch2
    gr_log.delete();
    req = 4'b0111;
    for (int n = 0; n < 3; n++) req_addr[n*AW +: AW] = AW'($urandom);
    tick();
    req = '0;
    wait_idle("simul");
    chk("simul_count", gr_log.size(), 3);
    for (int i = 0; i < 3 && i < gr_log.size(); i++)
      chk("simul_order", gr_log[i], i);

    // ch3 starvation under continuous ch0 traffic
    gr_log.delete();
    req = 4'b1001;
    req_addr[0 +: AW] = AW'($urandom);
    req_addr[3*AW +: AW] = AW'($urandom);
    wr_data = 16'hBEEF;
    wr_bs = 2'b01;
    tick();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      req = 4'b0001;
      req_addr[0 +: AW] = AW'($urandom);
      tick();
      foreach (gr_log[j]) if (gr_log[j] == 3) found = 1;
    end
    req = '0;
    chk("starve_ch3_served", found, 1);
    wait_idle("starve");
    k = -1;
    foreach (gr_log[j]) if (gr_log[j] == 3 && k < 0) k = j;
    chk("starve_ch0_grants", k, 4);

    // overrun on ch2 while queued behind ch1
    do_reset();
    req = 4'b0010;
    req_addr[AW +: AW] = AW'($urandom);
    tick();
    req = 4'b0100;
    req_addr[2*AW +: AW] = 26'h0000AAA;
    tick();
    req = 4'b0100;
    req_addr[2*AW +: AW] = 26'h0000BBB;
    tick();
    req = '0;
    wait_idle("overrun");
    chk("overrun_flag", OVERRUN, 4'b0100);
    n0 = 0;
    foreach (gr_log[j]) if (gr_log[j] == 2) n0++;
    chk("overrun_ch2_once", n0, 1);

    // reset in the middle of a ch0 read
    stall = 1;
    req = 4'b0001;
    req_addr[0 +: AW] = AW'($urandom);
    tick();
    req = '0;
    repeat (3) tick();
    chk("rst_mid_pre_rd", SDRAM_RD, 1);
    #2 rst = 1'b1;
    clear_model();
    #1;
    chk("rst_mid_rd_async", SDRAM_RD, 0);
    chk("rst_mid_done", DONE, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stall = 0;
    repeat (5) tick();
    chk("rst_mid_no_pend", BUSY, 0);
    gr_log.delete();
    req = 4'b0001;
    req_addr[0 +: AW] = AW'($urandom);
    tick();
    req = '0;
    wait_idle("post_rst");
    chk("post_rst_served", gr_log.size(), 1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 4; n++) begin
        req[n] = ($urandom_range(0, 5) == 0);
        req_addr[n*AW +: AW] = AW'($urandom);
      end
      wr_data = 16'($urandom);
      wr_bs = 2'($urandom);
      tick();
    end
    req = '0;
    wait_idle("random");
    chk("rand_overrun", OVERRUN, m_ovr);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // watchdog with a controller that never answers
    do_reset();
    stall = 1;
    tmo_mode = 1;
    req = 4'b0010;
    req_addr[AW +: AW] = AW'($urandom);
    tick();
    req = '0;
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (DONE != 4'd0) begin
        hit = 1;
        break;
      end
    end
    chk("tmo_done_seen", hit, 1);
    chk("tmo_rd_low", SDRAM_RD, 0);
    chk("tmo_flag", TIMEOUT, 1);
    tick();
    stall = 0;
    tmo_mode = 0;
`else
    hit = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
